// File: rtl/ode_ram_pkg.sv
// Shared types and default widths for the state-RAM vector reader.
package ode_ram_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN
  } rd_state_t;

  localparam int DEF_ADDRESS_SIZE = 4;
  localparam int DEF_WORD_SIZE    = 32;
  localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/ram_vec_reader_if.sv
// Command and output-stream bundle of the vector reader.
// RD_STRIDE_EN adds the cmd_stride field.
interface ram_vec_reader_if #(
  parameter int AW = 4,
  parameter int WW = 32
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
`ifdef RD_STRIDE_EN
  logic [AW-1:0] cmd_stride;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic          out_last;

`ifdef RD_STRIDE_EN
  modport master (
    output cmd_valid, cmd_base, cmd_len, cmd_stride,
    input  cmd_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );
  modport slave (
    input  cmd_valid, cmd_base, cmd_len, cmd_stride,
    output cmd_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );
`else
  modport master (
    output cmd_valid, cmd_base, cmd_len,
    input  cmd_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );
  modport slave (
    input  cmd_valid, cmd_base, cmd_len,
    output cmd_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );
`endif

endinterface

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO between the RAM read port and the output stream.
module ram_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] P1 = 1;
  localparam logic [PW:0]   C1 = 1;
  localparam logic [PW:0]   CF = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & (cnt_q != CF);
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + P1;
      if (do_pop)  rptr_q <= rptr_q + P1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + C1;
        2'b01:   cnt_q <= cnt_q - C1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/ram_vec_reader.sv
// Reads a vector of RAM words and streams it out through a FIFO.
// RD_STRIDE_EN enables a per-command address stride.
module ram_vec_reader
  import ode_ram_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  ram_vec_reader_if.slave         bus,
  output logic                    ram_we_o,
  output logic [ADDRESS_SIZE-1:0] ram_addr_o,
  input  logic [WORD_SIZE-1:0]    ram_rdata_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int AS = ADDRESS_SIZE;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FCAP = CW'(FIFO_DEPTH);
  localparam logic [AS:0]   R1   = 1;

  rd_state_t         state_q;
  logic [AS-1:0]     addr_q, step;
  logic [AS:0]       rem_q;
  logic              busy_q, done_q;
  logic [CW-1:0]     fcnt;
  logic              f_empty, push, pop, cmd_acc;
  logic [WORD_SIZE:0] head;

`ifdef RD_STRIDE_EN
  logic [AS-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = AS'(1);
`endif

  assign bus.cmd_ready = (state_q == RD_IDLE) & ~rst;
  assign cmd_acc       = bus.cmd_valid & bus.cmd_ready;
  // Full test uses the registered count; a same-cycle pop does not free a slot.
  assign push          = (state_q == RD_READ) & (fcnt < FCAP);
  assign pop           = bus.out_valid & bus.out_ready;

  assign bus.out_valid = ~f_empty;
  assign bus.out_data  = f_empty ? '0 : head[WORD_SIZE-1:0];
  assign bus.out_last  = ~f_empty & head[WORD_SIZE];

  assign ram_we_o   = 1'b0;
  assign ram_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  ram_rd_fifo #(
    .WIDTH (WORD_SIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({rem_q == R1, ram_rdata_i}),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fcnt),
    .empty_o (f_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RD_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        RD_IDLE: begin
          if (cmd_acc) begin
            rem_q <= bus.cmd_len;
`ifdef RD_STRIDE_EN
            stride_q <= bus.cmd_stride;
`endif
            if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= bus.cmd_base;
              busy_q  <= 1'b1;
              state_q <= RD_READ;
            end
          end
        end
        RD_READ: begin
          if (push) begin
            addr_q <= addr_q + step;
            rem_q  <= rem_q - R1;
            if (rem_q == R1) state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pop & bus.out_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= RD_IDLE;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_vec_reader.sv
// Randomized and directed bench for ram_vec_reader against a vector model.
module tb_ram_vec_reader;

  localparam int AS = 4;
  localparam int WS = 32;
  localparam int FD = 4;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_we;
  logic [AS-1:0] ram_addr;
  logic [WS-1:0] ram_rdata;
  logic          busy, done;
  logic [WS-1:0] ram [NW];

  int checks = 0;
  int errors = 0;

  ram_vec_reader_if #(.AW(AS), .WW(WS)) bus ();

  ram_vec_reader #(
    .ADDRESS_SIZE (AS),
    .WORD_SIZE    (WS),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_rdata_i (ram_rdata),
    .busy_o      (busy),
    .done_o      (done)
  );

  assign ram_rdata = ram[ram_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ram();
    for (int i = 0; i < NW; i++) ram[i] = $urandom;
  endtask

  task automatic run_vec(input int base, input int len,
                         input int stride, input int stall,
                         input bit rnd, input bit tchk);
    logic [WS:0] expq[$];
    logic [WS:0] got[$];
    int cyc, first_pop, last_cyc, done_at, done_n, we_bad;
    bit last_seen;
    for (int i = 0; i < len; i++)
      expq.push_back({i == len - 1, ram[(base + i * stride) % NW]});
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = AS'(base);
    bus.cmd_len   = (AS+1)'(len);
`ifdef RD_STRIDE_EN
    bus.cmd_stride = AS'(stride);
`endif
    step();
    bus.cmd_valid = 1'b0;
    if (len == 0) begin
      chk("len0_done", 64'(done), 64'd1);
      chk("len0_valid", 64'(bus.out_valid), 64'd0);
      chk("len0_busy", 64'(busy), 64'd0);
      step();
      chk("len0_done_end", 64'(done), 64'd0);
      chk("len0_ready", 64'(bus.cmd_ready), 64'd1);
      return;
    end
    chk("busy_start", 64'(busy), 64'd1);
    chk("valid_t1", 64'(bus.out_valid), 64'd0);
    cyc = 1; first_pop = -1; last_cyc = -10;
    done_at = -1; done_n = 0; we_bad = 0; last_seen = 0;
    while (cyc < 400) begin
      if (done) begin
        done_n++;
        done_at = cyc;
      end
      if (ram_we !== 1'b0) we_bad++;
      if (last_seen) break;
      if (stall >= FD && len > FD && cyc == stall + 1)
        chk("stall_addr_hold", 64'(ram_addr),
            64'((base + FD * stride) % NW));
      bus.out_ready = (cyc <= stall) ? 1'b0 :
                      rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back({bus.out_last, bus.out_data});
        if (first_pop < 0) first_pop = cyc;
        if (bus.out_last) begin
          last_seen = 1;
          last_cyc  = cyc;
        end
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("vec_finished", 64'(last_seen), 64'd1);
    chk("word_count", 64'(got.size()), 64'(len));
    for (int i = 0; i < len && i < got.size(); i++)
      chk($sformatf("word%0d_b%0d", i, base),
          64'(got[i]), 64'(expq[i]));
    chk("done_timing", 64'(done_at), 64'(last_cyc + 1));
    chk("done_once", 64'(done_n), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("ram_we_zero", 64'(we_bad), 64'd0);
    if (tchk) begin
      chk("first_pop_t2", 64'(first_pop), 64'd2);
      chk("last_pop_cyc", 64'(last_cyc), 64'(len + 1));
    end
  endtask

  initial begin
    int n, base, len, stride;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
`ifdef RD_STRIDE_EN
    bus.cmd_stride = '0;
`endif
    bus.out_ready = 1'b0;
    fill_ram();
    step();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

    ram[3] = 32'hAAAA_0001;
    ram[4] = 32'hBBBB_0002;
    ram[5] = 32'hCCCC_0003;
    ram[6] = 32'hDDDD_0004;
    run_vec(3, 4, 1, 0, 0, 1);

    run_vec(14, 4, 1, 0, 0, 1);
    run_vec(2, 8, 1, 10, 0, 0);
    run_vec(7, 0, 1, 0, 0, 0);
    run_vec(0, 16, 1, 0, 0, 1);

    fill_ram();
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = AS'(5);
    bus.cmd_len   = (AS+1)'(6);
`ifdef RD_STRIDE_EN
    bus.cmd_stride = AS'(1);
`endif
    step();
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      if (bus.out_valid) n++;
      step();
    end
    chk("rst_mid_popped", 64'(n), 64'd2);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    step();
    chk("abort_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();
    chk("abort_no_done", 64'(done), 64'd0);
    chk("abort_valid2", 64'(bus.out_valid), 64'd0);
    run_vec(0, 1, 1, 0, 0, 1);

`ifdef RD_STRIDE_EN
    run_vec(1, 4, 3, 0, 0, 1);
    run_vec(9, 3, 0, 0, 0, 1);
`endif

    for (int t = 0; t < 25; t++) begin
      fill_ram();
      base = $urandom_range(0, NW - 1);
      len  = $urandom_range(0, NW);
`ifdef RD_STRIDE_EN
      stride = $urandom_range(0, NW - 1);
`else
      stride = 1;
`endif
      run_vec(base, len, stride, $urandom_range(0, 6), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
